// File: rtl/unsigned_mult_arbiter_8x8.sv
// Two-requester round-robin front end feeding a two-stage 8x8 unsigned multiplier.
// The product is exact or approximate, as selected when the pair is accepted.
module unsigned_mult_arbiter_8x8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_x,
  input  logic [7:0]  req0_y,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_x,
  input  logic [7:0]  req1_y,
  input  logic        cfg_approx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_z,
  output logic        out_id,
  output logic [15:0] txn_count
);

  localparam int unsigned OP_W = 8;
  localparam int unsigned Z_W  = 16;

  logic            s1_valid_q, s1_valid_d;
  logic [OP_W-1:0] s1_x_q, s1_x_d;
  logic [OP_W-1:0] s1_y_q, s1_y_d;
  logic            s1_id_q, s1_id_d;
  logic            s1_apx_q, s1_apx_d;
  logic            out_valid_q, out_valid_d;
  logic [Z_W-1:0]  out_z_q, out_z_d;
  logic            out_id_q, out_id_d;
  logic            prio_q, prio_d;
  logic [Z_W-1:0]  txn_q, txn_d;

  logic            adv_c;
  logic            s1_open_c;
  logic            gnt_id_c;
  logic            accept_c;
  logic [Z_W-1:0]  exact_c;
  logic [Z_W-1:0]  approx_c;
  logic [Z_W-1:0]  corr_a_c;
  logic [Z_W-1:0]  corr_b_c;
  logic [Z_W-1:0]  hi_part_c;

  // Arbitration and acceptance; ready is forced low while reset is held.
  always_comb begin
    adv_c     = !out_valid_q || out_ready;
    s1_open_c = !s1_valid_q || adv_c;
    gnt_id_c  = (req0_valid && req1_valid) ? prio_q : req1_valid;
    req0_ready = !rst && s1_open_c && req0_valid && !gnt_id_c;
    req1_ready = !rst && s1_open_c && req1_valid &&  gnt_id_c;
    accept_c   = req0_ready || req1_ready;
  end

  // Exact and approximate products from the registered S1 operands.
  always_comb begin
    exact_c   = Z_W'(s1_x_q) * Z_W'(s1_y_q);
    hi_part_c = Z_W'(s1_y_q) * Z_W'(s1_x_q[7:2]);
    corr_a_c  = '0;
    corr_b_c  = '0;
    corr_a_c[6] = (s1_x_q[0] & s1_y_q[6]) | (s1_x_q[1] & s1_y_q[4]);
    corr_a_c[7] = (s1_x_q[0] & s1_y_q[7]) ^ (s1_x_q[1] & s1_y_q[6]);
    corr_a_c[8] = (s1_x_q[0] & s1_y_q[7]) & (s1_x_q[1] & s1_y_q[6]);
    corr_b_c[6] = (s1_x_q[0] & s1_y_q[5]) | (s1_x_q[1] & s1_y_q[5]);
    corr_b_c[8] = s1_x_q[1] & s1_y_q[7];
    approx_c  = (hi_part_c << 2) + corr_a_c + corr_b_c;
  end

  // Next-state for both pipeline stages, the priority pointer and the counter.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_x_d      = s1_x_q;
    s1_y_d      = s1_y_q;
    s1_id_d     = s1_id_q;
    s1_apx_d    = s1_apx_q;
    out_valid_d = out_valid_q;
    out_z_d     = out_z_q;
    out_id_d    = out_id_q;
    prio_d      = prio_q;
    txn_d       = txn_q;

    if (adv_c) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_z_d  = s1_apx_q ? approx_c : exact_c;
        out_id_d = s1_id_q;
      end
    end

    if (accept_c) begin
      s1_valid_d = 1'b1;
      s1_x_d     = gnt_id_c ? req1_x : req0_x;
      s1_y_d     = gnt_id_c ? req1_y : req0_y;
      s1_id_d    = gnt_id_c;
      s1_apx_d   = cfg_approx;
      prio_d     = !gnt_id_c;
    end else if (adv_c) begin
      s1_valid_d = 1'b0;
    end

    if (out_valid_q && out_ready) begin
      txn_d = txn_q + Z_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_id_q     <= 1'b0;
      s1_apx_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_z_q     <= '0;
      out_id_q    <= 1'b0;
      prio_q      <= 1'b0;
      txn_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      s1_id_q     <= s1_id_d;
      s1_apx_q    <= s1_apx_d;
      out_valid_q <= out_valid_d;
      out_z_q     <= out_z_d;
      out_id_q    <= out_id_d;
      prio_q      <= prio_d;
      txn_q       <= txn_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_z     = out_z_q;
  assign out_id    = out_id_q;
  assign txn_count = txn_q;

endmodule

// File: tb/tb_unsigned_mult_arbiter_8x8.sv
// Directed plus randomized checks of unsigned_mult_arbiter_8x8 against a
// transaction-level model (in-flight queue, visibility times, round-robin pointer).
module tb_unsigned_mult_arbiter_8x8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
  logic        cfg_approx = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_z;
  logic        out_id;
  logic [15:0] txn_count;

  unsigned_mult_arbiter_8x8 dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .cfg_approx(cfg_approx),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_id(out_id),
    .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] z;
    logic        id;
    int          acc;
  } item_t;

  item_t       q[$];
  logic        grants[$];
  int          cyc = 0;
  int          last_leave = -10;
  logic        mprio = 1'b0;
  logic [15:0] mtxn = '0;
  int          n_acc = 0;
  logic [15:0] last_z = '0;
  logic        last_id = 1'b0;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [15:0] ref_prod(input logic [7:0] x, input logic [7:0] y,
                                           input logic apx);
    int p, a, b;
    if (!apx) return 16'(int'(x) * int'(y));
    p = 4 * (int'(y) * int'(x >> 2));
    a = 64  * int'((x[0] & y[6]) | (x[1] & y[4]))
      + 128 * int'((x[0] & y[7]) ^ (x[1] & y[6]))
      + 256 * int'((x[0] & y[7]) & (x[1] & y[6]));
    b = 64  * int'((x[0] & y[5]) | (x[1] & y[5]))
      + 256 * int'(x[1] & y[7]);
    return 16'(p + a + b);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check, update the model, advance.
  task automatic step(input logic v0, input logic [7:0] x0, input logic [7:0] y0,
                      input logic v1, input logic [7:0] x1, input logic [7:0] y1,
                      input logic apx, input logic ordy);
    logic exp_ov, cap, g, e0, e1;
    int   vis;
    req0_valid = v0; req0_x = x0; req0_y = y0;
    req1_valid = v1; req1_x = x1; req1_y = y1;
    cfg_approx = apx; out_ready = ordy;
    #1;
    exp_ov = 1'b0;
    if (q.size() > 0) begin
      vis    = (q[0].acc + 2 > last_leave + 1) ? q[0].acc + 2 : last_leave + 1;
      exp_ov = (cyc >= vis);
    end
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      chk("out_z", 32'(out_z), 32'(q[0].z));
      chk("out_id", 32'(out_id), 32'(q[0].id));
      last_z  = out_z;
      last_id = out_id;
    end
    cap = (q.size() < 2) || (exp_ov && ordy);
    g   = (v0 && v1) ? mprio : v1;
    e0  = cap && v0 && !g;
    e1  = cap && v1 && g;
    chk("req0_ready", 32'(req0_ready), 32'(e0));
    chk("req1_ready", 32'(req1_ready), 32'(e1));
    chk("txn_count", 32'(txn_count), 32'(mtxn));
    if (exp_ov && ordy) begin
      void'(q.pop_front());
      last_leave = cyc;
      mtxn = mtxn + 16'd1;
    end
    if (e0 || e1) begin
      q.push_back('{z: ref_prod(g ? x1 : x0, g ? y1 : y0, apx), id: g, acc: cyc});
      grants.push_back(g);
      mprio = !g;
      n_acc++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, ordy);
  endtask

  // Assert reset mid-cycle with requesters still valid; check the asynchronous clear.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_z", 32'(out_z), 32'(0));
    chk("rst_out_id", 32'(out_id), 32'(0));
    chk("rst_txn", 32'(txn_count), 32'(0));
    chk("rst_req0_ready", 32'(req0_ready), 32'(0));
    chk("rst_req1_ready", 32'(req1_ready), 32'(0));
    q.delete();
    grants.delete();
    mprio = 1'b0;
    mtxn  = '0;
    last_leave = -10;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] x, y;
    logic       exp_rr[4];
    int         acc_before;

    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    do_reset();

    // Exact single transfer of 0xFF * 0xFF.
    step(1, 8'hFF, 8'hFF, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("exact_ff_z", 32'(last_z), 32'h0000FE01);
    chk("exact_ff_id", 32'(last_id), 32'(0));
    chk("exact_ff_txn", 32'(txn_count), 32'(1));

    // Requester 1, same pair in approximate then exact mode.
    step(0, 0, 0, 1, 8'h03, 8'hFF, 1, 1);
    idle(2, 1);
    chk("approx_03ff", 32'(last_z), 32'd640);
    chk("approx_id", 32'(last_id), 32'(1));
    step(0, 0, 0, 1, 8'h03, 8'hFF, 0, 1);
    idle(2, 1);
    chk("exact_03ff", 32'(last_z), 32'd765);

    // Round-robin with both requesters held valid.
    do_reset();
    exp_rr = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) step(1, 8'(i + 1), 8'h11, 1, 8'(i + 9), 8'h22, 0, 1);
    chk("rr_count", 32'(grants.size()), 32'(4));
    for (int i = 0; i < 4 && i < grants.size(); i++)
      chk($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(exp_rr[i]));

    // Back-pressure: at most one more pair fits, then everything drains in order.
    acc_before = n_acc;
    for (int i = 0; i < 5; i++) step(1, 8'h5A, 8'hC3, 1, 8'hA5, 8'h3C, 1, 0);
    chk("bp_accepts", 32'(n_acc - acc_before <= 1), 32'(1));
    idle(4, 1);
    chk("bp_drained", 32'(q.size()), 32'(0));

    // Reset with both stages full; no stale result afterwards, requester 0 first.
    step(1, 8'h12, 8'h34, 0, 0, 0, 0, 0);
    step(1, 8'h56, 8'h78, 0, 0, 0, 0, 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    do_reset();
    idle(3, 1);
    step(1, 8'h07, 8'h09, 1, 8'h0B, 8'h0D, 0, 1);
    chk("post_rst_grant", 32'(grants[0]), 32'(0));
    idle(3, 1);

    // Randomized traffic with random back-pressure and mode changes.
    for (int i = 0; i < 400; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      step(1'($urandom), x, y, 1'($urandom), 8'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    idle(6, 1);

    // Counter wrap: 65536 results from a fresh reset bring the counter back to zero.
    do_reset();
    for (int i = 0; i < 65536; i++) step(1, 8'(i), 8'(i >> 8), 0, 0, 0, 1'(i >> 3), 1);
    idle(3, 1);
    chk("txn_wrap", 32'(txn_count), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
